// File: rtl/tft_seq_pkg.sv
// rtl/tft_seq_pkg.sv - shared state encoding, default delays and helpers for the TFT power sequencer
package tft_seq_pkg;

    typedef enum logic [3:0] {
        ST_OFF     = 4'd0,
        ST_UP_TFT  = 4'd1,
        ST_UP_VID  = 4'd2,
        ST_UP_DISP = 4'd3,
        ST_UP_LED  = 4'd4,
        ST_ON      = 4'd5,
        ST_DN_LED  = 4'd6,
        ST_DN_DISP = 4'd7,
        ST_DN_VID  = 4'd8,
        ST_DN_TFT  = 4'd9
    } seq_state_t;

    localparam int DEF_CNT_W  = 16;
    localparam int DEF_T_PWR  = 4;
    localparam int DEF_T_VID  = 2;
    localparam int DEF_T_DISP = 2;
    localparam int DEF_T_LED  = 2;

    // A zero delay still occupies one cycle, so its reload value is 0 like a delay of 1.
    function automatic int step_reload(input int t);
        return (t < 1) ? 0 : t - 1;
    endfunction

    function automatic logic is_step(input seq_state_t s);
        return !(s == ST_OFF || s == ST_ON);
    endfunction

endpackage

// File: rtl/seq_delay_timer.sv
// rtl/seq_delay_timer.sv - loadable down-counter that flags the end of a sequencer step
module seq_delay_timer
    import tft_seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_out,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_out) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/tft_power_sequencer.sv
// rtl/tft_power_sequencer.sv - ordered TFT power-up/down sequencer; TFT_BACKLIGHT_PWM_EN adds backlight PWM
module tft_power_sequencer
    import tft_seq_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int T_PWR  = DEF_T_PWR,
    parameter int T_VID  = DEF_T_VID,
    parameter int T_DISP = DEF_T_DISP,
    parameter int T_LED  = DEF_T_LED
) (
    input  logic       clk_out,
    input  logic       rst_n,
    input  logic       on_req,
`ifdef TFT_BACKLIGHT_PWM_EN
    input  logic [7:0] brightness,
`endif
    output logic       TFT_en,
    output logic       de_en,
    output logic       rgb_en,
    output logic       pixel_en,
    output logic       en_sync,
    output logic       disp_en,
    output logic       led_en,
    output logic       ready,
    output logic       busy
);

    seq_state_t       state, next_state;
    logic             step_done;
    logic             timer_load;
    logic [CNT_W-1:0] load_val;
    logic             tft_d, vid_d, disp_d, led_d, ready_d, busy_d;
    logic             tft_q, vid_q, disp_q, led_q;

    seq_delay_timer #(.CNT_W(CNT_W)) u_timer (
        .clk_out  (clk_out),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (load_val),
        .dec      (is_step(state)),
        .zero     (step_done)
    );

    // Enables and status are registered from the decoded next state.
    always_ff @(posedge clk_out) begin
        if (!rst_n) begin
            state  <= ST_OFF;
            tft_q  <= 1'b0;
            vid_q  <= 1'b0;
            disp_q <= 1'b0;
            led_q  <= 1'b0;
            ready  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= next_state;
            tft_q  <= tft_d;
            vid_q  <= vid_d;
            disp_q <= disp_d;
            led_q  <= led_d;
            ready  <= ready_d;
            busy   <= busy_d;
        end
    end

    // Dropping on_req aborts an up step into its mirror down step; down steps ignore on_req.
    always_comb begin
        next_state = state;
        case (state)
            ST_OFF:     if (on_req)         next_state = ST_UP_TFT;
            ST_UP_TFT:  if (!on_req)        next_state = ST_DN_TFT;
                        else if (step_done) next_state = ST_UP_VID;
            ST_UP_VID:  if (!on_req)        next_state = ST_DN_VID;
                        else if (step_done) next_state = ST_UP_DISP;
            ST_UP_DISP: if (!on_req)        next_state = ST_DN_DISP;
                        else if (step_done) next_state = ST_UP_LED;
            ST_UP_LED:  if (!on_req)        next_state = ST_DN_LED;
                        else if (step_done) next_state = ST_ON;
            ST_ON:      if (!on_req)        next_state = ST_DN_LED;
            ST_DN_LED:  if (step_done)      next_state = ST_DN_DISP;
            ST_DN_DISP: if (step_done)      next_state = ST_DN_VID;
            ST_DN_VID:  if (step_done)      next_state = ST_DN_TFT;
            ST_DN_TFT:  if (step_done)      next_state = ST_OFF;
            default:                        next_state = ST_OFF;
        endcase
    end

    always_comb begin
        timer_load = (next_state != state) && is_step(next_state);
        load_val   = '0;
        case (next_state)
            ST_UP_TFT,  ST_DN_TFT:  load_val = CNT_W'(step_reload(T_PWR));
            ST_UP_VID,  ST_DN_VID:  load_val = CNT_W'(step_reload(T_VID));
            ST_UP_DISP, ST_DN_DISP: load_val = CNT_W'(step_reload(T_DISP));
            ST_UP_LED,  ST_DN_LED:  load_val = CNT_W'(step_reload(T_LED));
            default:                load_val = '0;
        endcase
    end

    always_comb begin
        tft_d   = 1'b0;
        vid_d   = 1'b0;
        disp_d  = 1'b0;
        led_d   = 1'b0;
        ready_d = (next_state == ST_ON);
        busy_d  = is_step(next_state);
        case (next_state)
            ST_UP_TFT, ST_DN_VID: tft_d = 1'b1;
            ST_UP_VID, ST_DN_DISP: begin
                tft_d = 1'b1;
                vid_d = 1'b1;
            end
            ST_UP_DISP, ST_DN_LED: begin
                tft_d  = 1'b1;
                vid_d  = 1'b1;
                disp_d = 1'b1;
            end
            ST_UP_LED, ST_ON: begin
                tft_d  = 1'b1;
                vid_d  = 1'b1;
                disp_d = 1'b1;
                led_d  = 1'b1;
            end
            default: ;
        endcase
    end

    assign TFT_en   = tft_q;
    assign de_en    = vid_q;
    assign rgb_en   = vid_q;
    assign pixel_en = vid_q;
    assign en_sync  = vid_q;
    assign disp_en  = disp_q;

`ifdef TFT_BACKLIGHT_PWM_EN
    logic [7:0] pwm_cnt;

    always_ff @(posedge clk_out) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    assign led_en = led_q & (pwm_cnt < brightness);
`else
    assign led_en = led_q;
`endif

endmodule
